// File: rtl/axis_hist_bins.sv
// axis_hist_bins: AXI-Stream histogram with record FIFO, framed bin dump and read port; define HIST_SAT_EN for saturating counters
module axis_hist_bins #(
  parameter int DATA_W     = 8,
  parameter int BIN_BITS   = 3,
  parameter int COUNT_W    = 32,
  parameter int FIFO_DEPTH = 16
)(
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic        dump_req,
  input  logic        clear_on_dump,
  input  logic        clear,
  output logic        dump_busy,
  output logic        ovf,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [31:0] rd_data
);
  localparam int NUM_BINS = 1 << BIN_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DUMP} state_t;
  state_t state, state_nxt;
  logic [COUNT_W-1:0] cnt [NUM_BINS];
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [BIN_BITS-1:0] p, bin;
  logic [COUNT_W-1:0] base, nxt;
  logic live, cod, empty, full, acc, hs, clr_all, unused;
  function automatic logic [31:0] rec(input logic [BIN_BITS-1:0] b, input logic [COUNT_W-1:0] c);
    logic [31:0] c32;
    c32 = 32'(c);
    return {8'(b), c32[23:0]};
  endfunction
  assign unused = ^{s_axis_tdata, rd_addr};
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // live keeps tready low through reset while remaining a pure register decode
  assign s_axis_tready = live && state == RUN && !full;
  assign acc = s_axis_tvalid && s_axis_tready;
  assign bin = s_axis_tdata[DATA_W-1 -: BIN_BITS];
  assign base = (state == RUN && clear) ? '0 : cnt[bin];
  assign m_axis_tvalid = state == DUMP || !empty;
  assign m_axis_tlast = state == DUMP && (&p);
  assign m_axis_tdata = state == DUMP ? rec(p, cnt[p]) : empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign hs = m_axis_tvalid && m_axis_tready;
  assign clr_all = (state == RUN && clear) || (m_axis_tlast && hs && cod);
  assign dump_busy = state != RUN;
`ifdef HIST_SAT_EN
  logic sat, ovf_r;
  assign sat = &base;
  assign nxt = sat ? base : base + COUNT_W'(1);
  assign ovf = ovf_r;
  always_ff @(posedge aclk)
    ovf_r <= areset ? 1'b0 : ((clr_all ? 1'b0 : ovf_r) | (acc && sat));
`else
  assign nxt = base + COUNT_W'(1);
  assign ovf = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    state_nxt = state == RUN ? (dump_req ? DRAIN : RUN) :
                state == DRAIN ? (empty ? DUMP : DRAIN) :
                (hs && m_axis_tlast) ? RUN : DUMP;
  end
  always_ff @(posedge aclk)
    if (acc) mem[wr_ptr[AW-1:0]] <= rec(bin, nxt);
  always_ff @(posedge aclk)
    if (areset) begin
      state <= RUN;
      live <= 1'b0;
      cod <= 1'b0;
      p <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
      for (int i = 0; i < NUM_BINS; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      live <= 1'b1;
      if (state == RUN && dump_req) cod <= clear_on_dump;
      p <= state == DRAIN ? '0 : (state == DUMP && hs) ? p + BIN_BITS'(1) : p;
      if (acc) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (hs && state != DUMP) rd_ptr <= rd_ptr + (AW+1)'(1);
      rd_data <= rd_en ? 32'(cnt[rd_addr[BIN_BITS-1:0]]) : '0;
      if (clr_all) for (int i = 0; i < NUM_BINS; i++) cnt[i] <= '0;
      if (acc) cnt[bin] <= nxt;
    end
endmodule
